// File: rtl/music_pkg.sv
// Types and constants shared by the song selector, change detector and note sequencer.
package music_pkg;

    localparam int SONG_W              = 2;
    localparam int NUM_SONGS_MAX       = 4;
    localparam int DEBOUNCE_CYCLES_DEF = 1_000_000;

    typedef logic [SONG_W-1:0] song_idx_t;

    // Forward step through the playlist, wrapping from the last index to 0.
    function automatic song_idx_t song_step_next(input song_idx_t cur, input song_idx_t last);
        return (cur == last) ? {SONG_W{1'b0}} : song_idx_t'(cur + song_idx_t'(1'b1));
    endfunction

    function automatic song_idx_t song_step_prev(input song_idx_t cur, input song_idx_t last);
        return (cur == {SONG_W{1'b0}}) ? last : song_idx_t'(cur - song_idx_t'(1'b1));
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One board key: two-flop synchronizer, stability counter, debounced level and
// a registered one-cycle pulse on each accepted press (falling debounced level).
module key_debounce
    import music_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_level_next;
    logic             w_press_next;

    // Count consecutive cycles where the synced key disagrees with the accepted level.
    always_comb begin
        w_cnt_next   = r_cnt;
        w_level_next = r_level;
        if (r_sync2 == r_level) begin
            w_cnt_next = {CNT_W{1'b0}};
        end else if (r_cnt == CNT_LAST) begin
            w_level_next = r_sync2;
            w_cnt_next   = {CNT_W{1'b0}};
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        w_press_next = r_level & ~w_level_next;
    end

    // Synchronizer, debounce state and press pulse; released (1) is the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_cnt   <= {CNT_W{1'b0}};
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_level <= w_level_next;
            r_cnt   <= w_cnt_next;
            r_press <= w_press_next;
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/song_select.sv
// Song-selection front end: debounced next/prev/play keys plus end-of-song
// auto-advance drive the registered song index and play/pause enable.
module song_select
    import music_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int NUM_SONGS       = NUM_SONGS_MAX
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      key_next_n,
    input  logic      key_prev_n,
    input  logic      key_play_n,
    input  logic      song_done,
    output song_idx_t music_reg,
    output logic      play_en
);

    localparam song_idx_t LAST_IDX = song_idx_t'(NUM_SONGS - 1);

    logic      w_next_ev;
    logic      w_prev_ev;
    logic      w_play_ev;
    song_idx_t r_music;
    song_idx_t w_music_next;
    logic      r_play;
    logic      w_play_next;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_next_n),
        .o_press (w_next_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_prev_n),
        .o_press (w_prev_ev)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_key_n (key_play_n),
        .o_press (w_play_ev)
    );

    // Any key event masks song_done; opposing next/prev cancel each other.
    always_comb begin
        w_music_next = r_music;
        if (w_next_ev && w_prev_ev) begin
            w_music_next = r_music;
        end else if (w_next_ev) begin
            w_music_next = song_step_next(r_music, LAST_IDX);
        end else if (w_prev_ev) begin
            w_music_next = song_step_prev(r_music, LAST_IDX);
        end else if (w_play_ev) begin
            w_music_next = r_music;
        end else if (song_done && r_play) begin
            w_music_next = song_step_next(r_music, LAST_IDX);
        end else begin
            w_music_next = r_music;
        end

        if (w_play_ev) begin
            w_play_next = ~r_play;
        end else begin
            w_play_next = r_play;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_music <= {SONG_W{1'b0}};
            r_play  <= 1'b0;
        end else begin
            r_music <= w_music_next;
            r_play  <= w_play_next;
        end
    end

    assign music_reg = r_music;
    assign play_en   = r_play;

endmodule

// File: tb/tb_song_select.sv
// Scoreboard bench: a cycle-level behavioural model pushes expected outputs per
// edge, a monitor pops and compares them against two DUTs (4 and 3 songs).
module tb_song_select;
    import music_pkg::*;

    localparam int DB = 4;

    logic      clk   = 1'b0;
    logic      rst_n = 1'b0;
    logic      kn    = 1'b1;
    logic      kp    = 1'b1;
    logic      kpl   = 1'b1;
    logic      done  = 1'b0;
    song_idx_t m4, m3;
    logic      p4, p3;

    always #5 clk = ~clk;

    song_select #(.DEBOUNCE_CYCLES(DB), .NUM_SONGS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .key_next_n(kn), .key_prev_n(kp),
        .key_play_n(kpl), .song_done(done), .music_reg(m4), .play_en(p4)
    );

    song_select #(.DEBOUNCE_CYCLES(DB), .NUM_SONGS(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .key_next_n(kn), .key_prev_n(kp),
        .key_play_n(kpl), .song_done(done), .music_reg(m3), .play_en(p3)
    );

    typedef struct packed {
        logic [1:0] m4;
        logic [1:0] m3;
        logic       play;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int   m4e = 0;
    int   m3e = 0;
    bit   pe  = 1'b0;
    int   lvl[3];
    int   run[3];
    int   due_next[$];
    int   due_prev[$];
    int   due_play[$];

    // Model: a key level is accepted after DB consecutive differing samples;
    // an accepted press acts on the outputs three edges after its last sample.
    initial begin
        int   t;
        bit   en, ep, el;
        int   raw;
        exp_t e;
        t = 0;
        forever begin
            @(posedge clk);
            t++;
            if (!rst_n) begin
                m4e = 0; m3e = 0; pe = 1'b0;
                for (int i = 0; i < 3; i++) begin lvl[i] = 1; run[i] = 0; end
                due_next.delete(); due_prev.delete(); due_play.delete();
            end else begin
                en = (due_next.size() > 0) && (due_next[0] == t);
                ep = (due_prev.size() > 0) && (due_prev[0] == t);
                el = (due_play.size() > 0) && (due_play[0] == t);
                if (en) void'(due_next.pop_front());
                if (ep) void'(due_prev.pop_front());
                if (el) void'(due_play.pop_front());
                if (en && !ep) begin
                    m4e = (m4e + 1) % 4; m3e = (m3e + 1) % 3;
                end else if (ep && !en) begin
                    m4e = (m4e + 3) % 4; m3e = (m3e + 2) % 3;
                end else if (!en && !ep && !el && done && pe) begin
                    m4e = (m4e + 1) % 4; m3e = (m3e + 1) % 3;
                end
                if (el) pe = !pe;
                for (int i = 0; i < 3; i++) begin
                    raw = (i == 0) ? int'(kn) : (i == 1) ? int'(kp) : int'(kpl);
                    if (raw != lvl[i]) run[i]++; else run[i] = 0;
                    if (run[i] == DB) begin
                        lvl[i] = raw;
                        run[i] = 0;
                        if (raw == 0) begin
                            if (i == 0) due_next.push_back(t + 3);
                            else if (i == 1) due_prev.push_back(t + 3);
                            else due_play.push_back(t + 3);
                        end
                    end
                end
            end
            e.m4 = 2'(m4e); e.m3 = 2'(m3e); e.play = pe;
            sb_q.push_back(e);
        end
    end

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare each registered output shortly after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got 0 entries expected 1 at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                chk("music4", m4, e.m4);
                chk("music3", m3, e.m3);
                chk("play4", {1'b0, p4}, {1'b0, e.play});
                chk("play3", {1'b0, p3}, {1'b0, e.play});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k);
        if (k == 0) kn = 1'b0; else if (k == 1) kp = 1'b0; else kpl = 1'b0;
        cyc(8);
        kn = 1'b1; kp = 1'b1; kpl = 1'b1;
        cyc(8);
    endtask

    // Directed scenarios followed by randomized key/song_done traffic.
    initial begin
        int hold;
        cyc(3);
        rst_n = 1'b1;
        cyc(3);
        kn = 1'b0; cyc(1); kn = 1'b1; cyc(1); kn = 1'b0; cyc(1); kn = 1'b1; cyc(1);
        kn = 1'b0; cyc(20); kn = 1'b1; cyc(10);
        repeat (3) press(0);
        press(1);
        kp = 1'b0; cyc(3); kp = 1'b1; cyc(8);
        kn = 1'b0; kp = 1'b0; cyc(10); kn = 1'b1; kp = 1'b1; cyc(10);
        done = 1'b1; cyc(1); done = 1'b0; cyc(3);
        press(2);
        kn = 1'b0; cyc(6); done = 1'b1; cyc(1); done = 1'b0; cyc(6); kn = 1'b1; cyc(8);
        for (int i = 0; i < 4 && m4e != 3; i++) press(0);
        done = 1'b1; cyc(1); done = 1'b0; cyc(4);
        kn = 1'b0; cyc(2); rst_n = 1'b0; cyc(2); rst_n = 1'b1; cyc(12); kn = 1'b1; cyc(8);
        press(0); press(0); press(1); press(1);
        repeat (300) begin
            kn   = 1'($urandom_range(0, 1));
            kp   = 1'($urandom_range(0, 1));
            kpl  = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
            done = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
            if ($urandom_range(0, 59) == 0) rst_n = 1'b0;
            hold = $urandom_range(1, 9);
            cyc(1);
            done  = 1'b0;
            rst_n = 1'b1;
            cyc(hold - 1);
        end
        kn = 1'b1; kp = 1'b1; kpl = 1'b1; done = 1'b0;
        cyc(10);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
